// File: rtl/capture_readout.sv
// Streams a window of the capture RAM to the host link, one sample per handshake.
// Latency: start edge to first tx_valid is 3 cycles; best case one sample per 3 cycles.
// Backpressure: tx_data/tx_valid are held until tx_ready; no new RAM read is issued meanwhile.
// Optional checksum trailer byte is compiled in with `define READOUT_CHECKSUM_EN.
module capture_readout #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [31:0]       control,
   input  logic [31:0]       config0,
   input  logic [31:0]       config1,
   output logic [31:0]       status,
   output logic [ADDR_W-1:0] address,
   output logic              en,
   input  logic [DATA_W-1:0] datain,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

`ifdef READOUT_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4,
      S_TRAIL = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;
`endif

   state_t            state, state_nx;
   logic              start_q, start_q_nx;
   // armed stays low after reset until control[0] has been seen low, so a
   // start bit that is already high when reset releases cannot launch a readout
   logic              armed, armed_nx;
   logic [ADDR_W-1:0] ptr, ptr_nx;
   logic [ADDR_W:0]   cnt, cnt_nx;
   logic [ADDR_W:0]   sent, sent_nx;
   logic              busy, busy_nx;
   logic              done, done_nx;
   logic              aborted, aborted_nx;
   logic [ADDR_W-1:0] address_nx;
   logic              en_nx;
   logic [DATA_W-1:0] tx_data_nx;
   logic              tx_valid_nx;
   logic              start_edge;
   logic [ADDR_W:0]   sent_inc;
   logic [ADDR_W-1:0] ptr_inc;
`ifdef READOUT_CHECKSUM_EN
   logic [DATA_W-1:0] xsum, xsum_nx;
`endif
   logic              unused_bits;

   assign unused_bits = ^{control[31:2], config0[31:ADDR_W], config1[31:ADDR_W+1]};
   assign start_edge  = control[0] & ~start_q & armed;
   assign sent_inc    = sent + (ADDR_W+1)'(1);
   // the pointer is exactly ADDR_W wide, so the increment wraps the circular buffer
   assign ptr_inc     = ptr + ADDR_W'(1);

   assign status = {16'(sent), 13'd0, aborted, done, busy};

   // next-state and datapath decisions; every register keeps its value unless changed
   always_comb begin
      state_nx    = state;
      start_q_nx  = control[0];
      armed_nx    = armed | ~control[0];
      ptr_nx      = ptr;
      cnt_nx      = cnt;
      sent_nx     = sent;
      busy_nx     = busy;
      done_nx     = done;
      aborted_nx  = aborted;
      address_nx  = address;
      en_nx       = 1'b0;
      tx_data_nx  = tx_data;
      tx_valid_nx = tx_valid;
`ifdef READOUT_CHECKSUM_EN
      xsum_nx     = xsum;
`endif
      if (busy && control[1]) begin
         // abort wins over everything while a readout is in flight
         state_nx    = S_IDLE;
         busy_nx     = 1'b0;
         aborted_nx  = 1'b1;
         tx_valid_nx = 1'b0;
         en_nx       = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_edge && !control[1]) begin
                  cnt_nx     = config1[ADDR_W:0];
                  ptr_nx     = config0[ADDR_W-1:0];
                  sent_nx    = '0;
                  done_nx    = 1'b0;
                  aborted_nx = 1'b0;
`ifdef READOUT_CHECKSUM_EN
                  xsum_nx    = '0;
`endif
                  if (config1[ADDR_W:0] == '0) begin
                     state_nx = S_DONE;
                     busy_nx  = 1'b0;
                     done_nx  = 1'b1;
                  end else begin
                     state_nx   = S_ISSUE;
                     busy_nx    = 1'b1;
                     en_nx      = 1'b1;
                     address_nx = config0[ADDR_W-1:0];
                  end
               end
            end
            S_ISSUE: begin
               state_nx = S_WAIT;
            end
            S_WAIT: begin
               tx_data_nx  = datain;
               tx_valid_nx = 1'b1;
               state_nx    = S_HOLD;
            end
            S_HOLD: begin
               if (tx_ready) begin
                  tx_valid_nx = 1'b0;
                  sent_nx     = sent_inc;
                  ptr_nx      = ptr_inc;
`ifdef READOUT_CHECKSUM_EN
                  xsum_nx     = xsum ^ tx_data;
`endif
                  if (sent_inc == cnt) begin
`ifdef READOUT_CHECKSUM_EN
                     state_nx    = S_TRAIL;
                     tx_data_nx  = xsum ^ tx_data;
                     tx_valid_nx = 1'b1;
`else
                     state_nx = S_DONE;
                     busy_nx  = 1'b0;
                     done_nx  = 1'b1;
`endif
                  end else begin
                     state_nx   = S_ISSUE;
                     en_nx      = 1'b1;
                     address_nx = ptr_inc;
                  end
               end
            end
`ifdef READOUT_CHECKSUM_EN
            S_TRAIL: begin
               if (tx_ready) begin
                  tx_valid_nx = 1'b0;
                  state_nx    = S_DONE;
                  busy_nx     = 1'b0;
                  done_nx     = 1'b1;
               end
            end
`endif
            S_DONE: begin
               state_nx = S_IDLE;
            end
            default: begin
               state_nx = S_IDLE;
            end
         endcase
      end
   end

   // state and datapath registers with asynchronous clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= S_IDLE;
         start_q  <= 1'b0;
         armed    <= 1'b0;
         ptr      <= '0;
         cnt      <= '0;
         sent     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
         address  <= '0;
         en       <= 1'b0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
         xsum     <= '0;
`endif
      end else begin
         state    <= state_nx;
         start_q  <= start_q_nx;
         armed    <= armed_nx;
         ptr      <= ptr_nx;
         cnt      <= cnt_nx;
         sent     <= sent_nx;
         busy     <= busy_nx;
         done     <= done_nx;
         aborted  <= aborted_nx;
         address  <= address_nx;
         en       <= en_nx;
         tx_data  <= tx_data_nx;
         tx_valid <= tx_valid_nx;
`ifdef READOUT_CHECKSUM_EN
         xsum     <= xsum_nx;
`endif
      end
   end

endmodule

// File: tb/tb_capture_readout.sv
// Bench for capture_readout: RAM model, randomized readouts checked against a queue-based reference.
// Latency and throughput are checked on full-rate runs; backpressure, abort and reset on directed runs.
// Checksum trailer expectations follow READOUT_CHECKSUM_EN when it is defined.
module tb_capture_readout;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;
`ifdef READOUT_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic [31:0]       control = '0;
   logic [31:0]       config0 = '0;
   logic [31:0]       config1 = '0;
   logic [31:0]       status;
   logic [ADDR_W-1:0] address;
   logic              en;
   logic [DATA_W-1:0] datain = '0;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready = 1'b0;

   logic [DATA_W-1:0] ram [DEPTH];
   int                addr_q[$];
   logic [DATA_W-1:0] tx_q[$];
   int                stab_err = 0;
   int                n_cmp = 0;
   int                n_bad = 0;
   logic              prev_v = 0, prev_r = 0, prev_ab = 0;
   logic [DATA_W-1:0] prev_d = '0;

   capture_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .resetn(resetn), .control(control), .config0(config0), .config1(config1),
      .status(status), .address(address), .en(en), .datain(datain),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   // synchronous-read RAM: data one cycle after the enable cycle
   always @(posedge clk) if (en) datain <= ram[address];

   // observe at the falling edge: read addresses, accepted bytes, and hold stability
   always @(negedge clk) begin
      if (!resetn) begin
         prev_v = 0; prev_r = 0; prev_ab = 0;
      end else begin
         if (en) addr_q.push_back(int'(address));
         if (tx_valid && tx_ready && !control[1]) tx_q.push_back(tx_data);
         if (prev_v && !prev_r && !prev_ab && (!tx_valid || tx_data !== prev_d)) stab_err++;
         prev_v = tx_valid; prev_r = tx_ready; prev_ab = control[1]; prev_d = tx_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // mode 0: plain run; mode 1: stall 2nd sample 10 cycles; mode 2: abort in HOLD of 3rd sample
   task automatic run_readout(input int base, input int n, input int mode, input int rdy_pct);
      int first_v, done_c, low_cnt, hold_bad, exp_na, exp_nt, budget;
      logic [DATA_W-1:0] exp_b[$];
      logic [DATA_W-1:0] x;
      bit ab;
      addr_q.delete(); tx_q.delete(); stab_err = 0;
      first_v = -1; done_c = -1; low_cnt = 0; hold_bad = 0; ab = 0;
      budget = 20 * n + 60;
      config0 = base; config1 = n;
      tx_ready = (rdy_pct >= 100);
      control[0] = 1'b1;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(posedge clk); #1;
         if (first_v < 0 && tx_valid) first_v = cyc;
         if (status[1]) begin done_c = cyc; break; end
         if (cyc == 2) begin config0 = $urandom; config1 = $urandom; end
         if (cyc == 3) control[0] = 1'b0;
         if (cyc == 6 && status[0]) control[0] = 1'b1;
         tx_ready = ($urandom_range(99) < rdy_pct);
         if (mode == 1 && tx_q.size() == 1 && tx_valid && low_cnt < 10) begin
            tx_ready = 1'b0;
            low_cnt++;
            if (tx_data !== 8'd1 || tx_valid !== 1'b1) hold_bad++;
         end
         if (mode == 2 && tx_q.size() == 2 && tx_valid) begin
            tx_ready = 1'b0;
            control[1] = 1'b1;
            @(posedge clk); #1;
            check("abort_txv", tx_valid, 0);
            check("abort_en", en, 0);
            check("abort_status", status[2:0], 3'b100);
            control[1] = 1'b0;
            ab = 1;
            break;
         end
      end
      control[0] = 1'b0; tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // reference: the window of RAM read circularly, plus an XOR trailer when enabled
      x = '0;
      for (int i = 0; i < n; i++) begin
         exp_b.push_back(ram[(base + i) % DEPTH]);
         x ^= ram[(base + i) % DEPTH];
      end
      if (CK == 1 && !ab) exp_b.push_back(x);
      exp_na = ab ? 3 : n;
      exp_nt = ab ? 2 : exp_b.size();
      if (!ab) begin
         check("done_seen", done_c > 0, 1);
         check("status", status, {16'(n), 16'h0002});
      end
      check("n_addr", addr_q.size(), exp_na);
      for (int i = 0; i < addr_q.size() && i < exp_na; i++) begin
         check("addr", addr_q[i], (base + i) % DEPTH);
         if (addr_q[i] != (base + i) % DEPTH) break;
      end
      check("n_tx", tx_q.size(), exp_nt);
      for (int i = 0; i < tx_q.size() && i < exp_nt; i++) begin
         check("tx_byte", tx_q[i], exp_b[i]);
         if (tx_q[i] !== exp_b[i]) break;
      end
      check("stable", stab_err, 0);
      if (mode == 0 && rdy_pct >= 100 && n > 0) begin
         check("latency", first_v, 3);
         check("done_cyc", done_c, 3 * n + 1 + CK);
      end
      if (n == 0) check("zero_done_2cyc", (done_c >= 1 && done_c <= 2), 1);
      if (mode == 1) begin
         check("hold_data", hold_bad, 0);
         check("hold_len", low_cnt, 10);
      end
   endtask

   initial begin
      int bad;
      for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check("rst_status", status, 0);
      check("rst_addr", address, 0);
      check("rst_en", en, 0);
      check("rst_txd", tx_data, 0);
      check("rst_txv", tx_valid, 0);
      resetn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // basic 4-sample window at full rate
      ram[16] = 8'd3; ram[17] = 8'd1; ram[18] = 8'd2; ram[19] = 8'd7;
      run_readout(16, 4, 0, 100);
      // wrap at the top of the buffer
      run_readout(12'hFFE, 4, 0, 100);
      // 2nd sample stalled by the host
      ram[(100 + 1) % DEPTH] = 8'd1;
      run_readout(100, 4, 1, 100);
      // empty window
      run_readout($urandom_range(DEPTH - 1), 0, 0, 100);
      // abort, then a clean restart
      run_readout(200, 6, 2, 100);
      run_readout(300, 5, 0, 100);

      // reset in the middle of a readout with the start bit still high
      config0 = 500; config1 = 20; control[0] = 1'b1;
      repeat (8) @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      check("mid_rst_status", status, 0);
      check("mid_rst_addr", address, 0);
      check("mid_rst_en", en, 0);
      check("mid_rst_txd", tx_data, 0);
      check("mid_rst_txv", tx_valid, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      tx_ready = 1'b1;
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (en || tx_valid || status[0]) bad++;
      end
      check("no_restart", bad, 0);
      control[0] = 1'b0; tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // randomized windows and host readiness
      for (int r = 0; r < 10; r++) begin
         int n;
         n = (r == 0) ? 1 : $urandom_range(40, 2);
         run_readout($urandom_range(DEPTH - 1), n, 0, (r % 3 == 0) ? 100 : $urandom_range(90, 20));
      end
      // full buffer
      run_readout($urandom_range(DEPTH - 1), DEPTH, 0, 100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
